// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : round-robin, packet-locked sharing of one uart_tx.  rev 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int GAP_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 tx_wr,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready
);

  localparam int                 PTR_W = $clog2(NUM_REQ);
  localparam logic [7:0]         C_GAP = 8'(GAP_CYCLES);
  localparam logic [NUM_REQ-1:0] C_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEND  = 3'd1,
    S_GUARD = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_last, w_last_nxt;
  logic [PTR_W-1:0]   r_gidx, w_gidx_nxt;
  logic               r_last_flag, w_last_flag_nxt;
  logic [7:0]         r_gap_cnt, w_gap_cnt_nxt;
  logic [NUM_REQ-1:0] w_grant_nxt, w_ack_nxt;
  logic               w_busy_nxt, w_tx_wr_nxt;
  logic [7:0]         w_tx_data_nxt;

  logic               w_hi_found, w_lo_found, w_found;
  logic [PTR_W-1:0]   w_hi_pick, w_lo_pick, w_pick;

  // Round-robin search: lowest requester above the pointer wins, otherwise
  // wrap around to the lowest requester at or below it.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_pick  = '0;
    w_lo_pick  = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_valid[j]) begin
        if (PTR_W'(j) > r_last) begin
          w_hi_found = 1'b1;
          w_hi_pick  = PTR_W'(j);
        end else begin
          w_lo_found = 1'b1;
          w_lo_pick  = PTR_W'(j);
        end
      end
    end
    w_found = w_hi_found | w_lo_found;
    w_pick  = w_hi_found ? w_hi_pick : w_lo_pick;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_gidx_nxt      = r_gidx;
    w_last_flag_nxt = r_last_flag;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_grant_nxt     = grant;
    w_ack_nxt       = '0;
    w_tx_wr_nxt     = 1'b0;
    w_tx_data_nxt   = tx_data;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_SEND;
          w_gidx_nxt  = w_pick;
          w_grant_nxt = C_ONE << w_pick;
        end
      end

      S_SEND: begin
        if (tx_ready && req_valid[r_gidx]) begin
          w_tx_wr_nxt     = 1'b1;
          w_tx_data_nxt   = req_data[{r_gidx, 3'b000} +: 8];
          w_ack_nxt       = grant;
          w_last_flag_nxt = req_last[r_gidx];
          w_state_nxt     = S_GUARD;
        end
      end

      // uart_tx only drops ready one cycle after the write; skip that cycle.
      S_GUARD: begin
        w_state_nxt = S_WAIT;
      end

      S_WAIT: begin
        if (tx_ready) begin
          if (!r_last_flag) begin
            w_state_nxt = S_SEND;
          end else begin
            w_last_nxt  = r_gidx;
            w_grant_nxt = '0;
            if (GAP_CYCLES > 0) begin
              w_state_nxt   = S_GAP;
              w_gap_cnt_nxt = C_GAP;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
      end

      S_GAP: begin
        if (r_gap_cnt <= 8'd1) begin
          w_state_nxt   = S_IDLE;
          w_gap_cnt_nxt = 8'd0;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 8'd1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_last      <= PTR_W'(NUM_REQ - 1);
      r_gidx      <= '0;
      r_last_flag <= 1'b0;
      r_gap_cnt   <= 8'd0;
      grant       <= '0;
      req_ack     <= '0;
      busy        <= 1'b0;
      tx_wr       <= 1'b0;
      tx_data     <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_gidx      <= w_gidx_nxt;
      r_last_flag <= w_last_flag_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      grant       <= w_grant_nxt;
      req_ack     <= w_ack_nxt;
      busy        <= w_busy_nxt;
      tx_wr       <= w_tx_wr_nxt;
      tx_data     <= w_tx_data_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_uart_tx_arbiter : requester/uart models plus round-robin packet model.
// ============================================================================
module tb_uart_tx_arbiter;
  localparam int N = 3;

  typedef struct { int cyc; int owner; logic [7:0] data; logic [N-1:0] ack; } wr_t;
  typedef struct { int owner; logic [7:0] data; } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [N-1:0] req_valid = '0, req_last = '0;
  logic [N*8-1:0] req_data = '0;
  logic tx_ready = 1'b1;
  logic sel = 1'b0;

  logic [N-1:0] ack0, grant0, ack5, grant5;
  logic busy0, busy5, wr0, wr5;
  logic [7:0] data0, data5;

  logic [N-1:0] ack_m, grant_m;
  logic busy_m, wr_m;
  logic [7:0] data_m;
  assign ack_m   = sel ? ack5   : ack0;
  assign grant_m = sel ? grant5 : grant0;
  assign busy_m  = sel ? busy5  : busy0;
  assign wr_m    = sel ? wr5    : wr0;
  assign data_m  = sel ? data5  : data0;

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ack(ack0), .grant(grant0), .busy(busy0),
    .tx_wr(wr0), .tx_data(data0), .tx_ready(tx_ready));

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(5)) u_dut_gap (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ack(ack5), .grant(grant5), .busy(busy5),
    .tx_wr(wr5), .tx_data(data5), .tx_ready(tx_ready));

  always #5 clk = ~clk;

  logic [8:0] rq [N][$];
  logic [N-1:0] hold_off = '0;
  logic ready_force_low = 1'b0;
  int busy_cnt = 0, busy_len = 0, cyc = 0;
  bit rand_busy = 1'b0;
  wr_t wlog[$];
  int n_checks = 0, n_errors = 0;

  function automatic int onehot_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0 && !hold_off[i]) begin
        req_valid[i] = 1'b1;
        req_data[i*8 +: 8] = rq[i][0][7:0];
        req_last[i] = rq[i][0][8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i] = 1'b0;
      end
    end
    tx_ready = (busy_cnt == 0) && !ready_force_low;
  endtask

  // One clock: sample outputs after the edge, advance uart/requester models.
  task automatic step();
    @(posedge clk); #1;
    cyc++;
    if (wr_m) begin
      wr_t e;
      e.cyc = cyc; e.owner = onehot_idx(grant_m); e.data = data_m; e.ack = ack_m;
      wlog.push_back(e);
      busy_cnt = rand_busy ? int'($urandom_range(0, 5)) : busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    for (int i = 0; i < N; i++)
      if (ack_m[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    n_checks++;
    if (!($countones(grant_m) <= 1 && (ack_m & ~grant_m) == '0 && wr_m == |ack_m)) begin
      n_errors++;
      $display("FAIL invariant cyc=%0d grant=%b ack=%b tx_wr=%b", cyc, grant_m, ack_m, wr_m);
    end
    drive_inputs();
  endtask

  task automatic apply_reset(input logic use_gap);
    sel = use_gap;
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) rq[i].delete();
    hold_off = '0; ready_force_low = 1'b0; busy_cnt = 0; busy_len = 0; rand_busy = 1'b0;
    wlog.delete();
    drive_inputs();
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (grant_m !== '0) begin n_errors++; $display("FAIL reset_grant got=%b want=000", grant_m); end
    n_checks++; if (ack_m !== '0) begin n_errors++; $display("FAIL reset_ack got=%b want=000", ack_m); end
    n_checks++; if (wr_m !== 1'b0) begin n_errors++; $display("FAIL reset_tx_wr got=%b want=0", wr_m); end
    n_checks++; if (data_m !== 8'h00) begin n_errors++; $display("FAIL reset_tx_data got=%h want=00", data_m); end
    n_checks++; if (busy_m !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b want=0", busy_m); end
    for (int i = 0; i < N; i++) rq[i].push_back({1'b1, 8'(8'h60 + i)});
    drive_inputs();
    @(posedge clk); #1;
    n_checks++; if (grant_m !== '0 || busy_m !== 1'b0) begin n_errors++; $display("FAIL reset_hold got=%b/%b want=000/0", grant_m, busy_m); end
    reset_n = 1'b1;
    step();
    n_checks++; if (grant_m !== 3'b001) begin n_errors++; $display("FAIL reset_first_grant got=%b want=001", grant_m); end
  endtask

  task automatic test_single_byte();
    int first_wr, acks;
    apply_reset(1'b0);
    busy_len = 10;
    rq[0].push_back({1'b1, 8'h41});
    drive_inputs();
    first_wr = -1; acks = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (wr_m && first_wr < 0) first_wr = k;
      if (ack_m[0]) acks++;
      if (k == 12) begin
        n_checks++; if (grant_m !== 3'b001) begin n_errors++; $display("FAIL single_grant_held got=%b want=001", grant_m); end
      end
      if (k == 13) begin
        n_checks++; if (grant_m !== 3'b000 || busy_m !== 1'b0) begin n_errors++; $display("FAIL single_idle got=%b/%b want=000/0", grant_m, busy_m); end
      end
    end
    n_checks++; if (first_wr != 2) begin n_errors++; $display("FAIL single_latency got=%0d want=2", first_wr); end
    n_checks++; if (wlog.size() != 1 || wlog[0].data !== 8'h41) begin n_errors++; $display("FAIL single_data got=%0d writes want=1 x 41", wlog.size()); end
    n_checks++; if (acks != 1) begin n_errors++; $display("FAIL single_acks got=%0d want=1", acks); end
  endtask

  task automatic test_multi_byte();
    logic [7:0] exp_b [3];
    bit pushed;
    exp_b[0] = 8'h4F; exp_b[1] = 8'h58; exp_b[2] = 8'h0A;
    apply_reset(1'b0);
    rq[1].push_back({1'b0, 8'h4F}); rq[1].push_back({1'b0, 8'h58}); rq[1].push_back({1'b1, 8'h0A});
    drive_inputs();
    pushed = 1'b0;
    for (int k = 0; k < 60 && wlog.size() < 4; k++) begin
      step();
      if (ack_m[1] && !pushed) begin
        rq[0].push_back({1'b1, 8'h30}); pushed = 1'b1; drive_inputs();
      end
    end
    n_checks++;
    if (wlog.size() != 4) begin
      n_errors++; $display("FAIL multi_count got=%0d want=4", wlog.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        if (j > 0) n_checks++;
        if (wlog[j].owner != 1 || wlog[j].data !== exp_b[j] || wlog[j].ack !== 3'b010) begin
          n_errors++; $display("FAIL multi_byte%0d got=%0d/%h/%b want=1/%h/010", j, wlog[j].owner, wlog[j].data, wlog[j].ack, exp_b[j]);
        end
      end
      n_checks++; if (wlog[3].owner != 0 || wlog[3].data !== 8'h30) begin n_errors++; $display("FAIL multi_next got=%0d/%h want=0/30", wlog[3].owner, wlog[3].data); end
      n_checks++; if (wlog[1].cyc - wlog[0].cyc != 3 || wlog[2].cyc - wlog[1].cyc != 3) begin n_errors++; $display("FAIL multi_spacing got=%0d,%0d want=3,3", wlog[1].cyc - wlog[0].cyc, wlog[2].cyc - wlog[1].cyc); end
    end
  endtask

  task automatic test_round_robin();
    apply_reset(1'b0);
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) rq[i].push_back({1'b1, 8'(16 * i + r)});
    drive_inputs();
    for (int k = 0; k < 100 && wlog.size() < 9; k++) step();
    n_checks++;
    if (wlog.size() != 9) begin
      n_errors++; $display("FAIL rr_count got=%0d want=9", wlog.size());
    end else begin
      for (int j = 0; j < 9; j++) begin
        n_checks++;
        if (wlog[j].owner != j % 3 || wlog[j].data !== 8'(16 * (j % 3) + j / 3)) begin
          n_errors++; $display("FAIL rr_slot%0d got=%0d/%h want=%0d/%h", j, wlog[j].owner, wlog[j].data, j % 3, 8'(16 * (j % 3) + j / 3));
        end
      end
    end
  endtask

  task automatic test_gap();
    int gapc;
    bit released, got;
    apply_reset(1'b1);
    rq[2].push_back({1'b1, 8'hA1}); rq[2].push_back({1'b1, 8'hA2});
    drive_inputs();
    gapc = 0; released = 1'b0; got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      step();
      if (wlog.size() > 0) begin
        if (grant_m == '0) released = 1'b1;
        if (released && grant_m != '0) got = 1'b1;
        else if (released && busy_m) gapc++;
      end
    end
    n_checks++; if (!got || gapc != 5) begin n_errors++; $display("FAIL gap_cycles got=%0d regrant=%0d want=5 regrant=1", gapc, got); end
    for (int k = 0; k < 20 && wlog.size() < 2; k++) step();
    n_checks++;
    if (wlog.size() != 2) begin n_errors++; $display("FAIL gap_second got=%0d writes want=2", wlog.size()); end
    else if (wlog[1].owner != 2 || wlog[1].data !== 8'hA2) begin n_errors++; $display("FAIL gap_second got=%0d/%h want=2/a2", wlog[1].owner, wlog[1].data); end
    sel = 1'b0;
  endtask

  task automatic test_stall_reset();
    bit bad;
    apply_reset(1'b0);
    rq[0].push_back({1'b0, 8'hC1}); rq[0].push_back({1'b0, 8'hC2}); rq[0].push_back({1'b1, 8'hC3});
    rq[1].push_back({1'b1, 8'hD1});
    drive_inputs();
    for (int k = 0; k < 10 && wlog.size() < 1; k++) step();
    n_checks++; if (wlog.size() != 1) begin n_errors++; $display("FAIL stall_first got=%0d writes want=1", wlog.size()); end
    hold_off[0] = 1'b1;
    drive_inputs();
    bad = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (grant_m !== 3'b001 || wr_m || ack_m != '0) bad = 1'b1;
    end
    n_checks++; if (bad) begin n_errors++; $display("FAIL stall_hold got=%b/%b want=001/0", grant_m, wr_m); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (grant_m !== '0 || ack_m !== '0 || wr_m !== 1'b0 || busy_m !== 1'b0 || data_m !== 8'h00) begin
      n_errors++; $display("FAIL async_reset got=%b/%b/%b/%b/%h want=000/000/0/0/00", grant_m, ack_m, wr_m, busy_m, data_m);
    end
    rq[0].delete();
    rq[0].push_back({1'b0, 8'hC1}); rq[0].push_back({1'b0, 8'hC2}); rq[0].push_back({1'b1, 8'hC3});
    hold_off = '0; busy_cnt = 0; wlog.delete();
    drive_inputs();
    #2 reset_n = 1'b1;
    step();
    n_checks++; if (grant_m !== 3'b001) begin n_errors++; $display("FAIL restart_grant got=%b want=001", grant_m); end
    for (int k = 0; k < 10 && wlog.size() < 1; k++) step();
    n_checks++; if (wlog.size() != 1 || wlog[0].data !== 8'hC1) begin n_errors++; $display("FAIL restart_data got=%0d writes want=1 x c1", wlog.size()); end
  endtask

  task automatic test_backpressure();
    bit bad;
    apply_reset(1'b0);
    ready_force_low = 1'b1;
    rq[1].push_back({1'b1, 8'h77});
    drive_inputs();
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (wr_m || ack_m != '0) bad = 1'b1;
    end
    n_checks++; if (bad || grant_m !== 3'b010) begin n_errors++; $display("FAIL bp_hold got=%b grant=%b want=0 grant=010", bad, grant_m); end
    ready_force_low = 1'b0;
    drive_inputs();
    step();
    n_checks++;
    if (wr_m !== 1'b1 || data_m !== 8'h77 || ack_m !== 3'b010) begin
      n_errors++; $display("FAIL bp_release got=%b/%h/%b want=1/77/010", wr_m, data_m, ack_m);
    end
  endtask

  // Random packets, random uart busy time; expected order from a plain
  // round-robin walk over whole packets.
  task automatic test_random();
    logic [8:0] mq [N][$];
    exp_t expq[$];
    exp_t x;
    logic [8:0] item;
    int ptr, c, npk, len, total;
    for (int it = 0; it < 4; it++) begin
      apply_reset(1'b0);
      rand_busy = 1'b1;
      expq.delete();
      total = 0;
      for (int i = 0; i < N; i++) begin
        mq[i].delete();
        npk = int'($urandom_range(0, 3));
        for (int p = 0; p < npk; p++) begin
          len = int'($urandom_range(1, 4));
          for (int b = 0; b < len; b++) begin
            item = {(b == len - 1), 8'($urandom)};
            rq[i].push_back(item); mq[i].push_back(item); total++;
          end
        end
      end
      ptr = N - 1;
      while (1) begin
        c = -1;
        for (int s = 1; s <= N; s++)
          if (c < 0 && mq[(ptr + s) % N].size() > 0) c = (ptr + s) % N;
        if (c < 0) break;
        do begin
          item = mq[c].pop_front();
          x.owner = c; x.data = item[7:0];
          expq.push_back(x);
        end while (!item[8]);
        ptr = c;
      end
      drive_inputs();
      for (int k = 0; k < 3000 && wlog.size() < total; k++) step();
      n_checks++;
      if (wlog.size() != total) begin
        n_errors++; $display("FAIL rand%0d_count got=%0d want=%0d", it, wlog.size(), total);
      end else begin
        for (int j = 0; j < total; j++) begin
          n_checks++;
          if (wlog[j].owner != expq[j].owner || wlog[j].data !== expq[j].data) begin
            n_errors++; $display("FAIL rand%0d_w%0d got=%0d/%h want=%0d/%h", it, j, wlog[j].owner, wlog[j].data, expq[j].owner, expq[j].data);
          end
        end
      end
      rand_busy = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_multi_byte();
    test_round_robin();
    test_gap();
    test_stall_reset();
    test_backpressure();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
